// File: rtl/blockstacker_pkg.sv
// Shared constants, FSM encoding and request payload for the block drawing path.
package blockstacker_pkg;

  localparam int unsigned CELL      = 4;
  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned MAX_CELLS = 4;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned WIDTH_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } block_req_t;

  // Requested width limited to the largest block we are able to draw.
  function automatic logic [WIDTH_W-1:0] clamp_width(input logic [WIDTH_W-1:0] width,
                                                     input int unsigned max_cells);
    if (32'(width) > max_cells) return WIDTH_W'(max_cells);
    return width;
  endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// Row-major pixel offset scanner over a block CELL rows tall and CELL*width columns wide.
module cell_scan_counter #(
  parameter int unsigned CELL    = 4,
  parameter int unsigned WIDTH_W = 3,
  parameter int unsigned CX_W    = 4,
  parameter int unsigned RY_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [WIDTH_W-1:0] width,
  output logic [CX_W-1:0]   cx,
  output logic [RY_W-1:0]   ry,
  output logic              last
);

  logic [CX_W:0] row_len;
  logic          row_end;
  logic          col_end;

  assign row_len = (CX_W+1)'(CELL * 32'(width));
  assign row_end = ({1'b0, cx} == row_len - (CX_W+1)'(1));
  assign col_end = (ry == RY_W'(CELL - 1));
  assign last    = row_end && col_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx <= '0;
      ry <= '0;
    end else if (clear) begin
      cx <= '0;
      ry <= '0;
    end else if (enable) begin
      if (row_end) begin
        cx <= '0;
        ry <= col_end ? '0 : ry + RY_W'(1);
      end else begin
        cx <= cx + CX_W'(1);
      end
    end
  end

endmodule

// File: rtl/block_drawer.sv
// Rasterises one block of CELL x CELL cells into VGA plot requests, clipping off-screen pixels.
module block_drawer #(
  parameter int unsigned CELL      = blockstacker_pkg::CELL,
  parameter int unsigned SCREEN_W  = blockstacker_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H  = blockstacker_pkg::SCREEN_H,
  parameter int unsigned MAX_CELLS = blockstacker_pkg::MAX_CELLS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic [2:0] width_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  import blockstacker_pkg::*;

  localparam int unsigned CX_W = (CELL * MAX_CELLS > 1) ? $clog2(CELL * MAX_CELLS) : 1;
  localparam int unsigned RY_W = (CELL > 1) ? $clog2(CELL) : 1;

  draw_state_t        state, next_state;
  block_req_t         req_q;
  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] eff_width;
  logic [CX_W-1:0]    cx;
  logic [RY_W-1:0]    ry;
  logic               last;
  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;
  logic               in_bounds;
  logic               accept;
  logic               plot_d;
  logic               done_d;

  assign eff_width = clamp_width(width_in, MAX_CELLS);

  cell_scan_counter #(
    .CELL    (CELL),
    .WIDTH_W (WIDTH_W),
    .CX_W    (CX_W),
    .RY_W    (RY_W)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != DRAW),
    .enable (state == DRAW),
    .width  (width_q),
    .cx     (cx),
    .ry     (ry),
    .last   (last)
  );

  // One extra bit on each sum so a block hanging off the right/bottom edge is clipped, not wrapped.
  assign x_sum     = {1'b0, req_q.x} + (X_W+1)'(cx);
  assign y_sum     = {1'b0, req_q.y} + (Y_W+1)'(ry);
  assign in_bounds = (32'(x_sum) < SCREEN_W) && (32'(y_sum) < SCREEN_H);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    plot_d     = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (eff_width == '0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        plot_d = in_bounds;
        if (last) next_state = DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch: later input changes cannot disturb a draw in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      width_q <= '0;
    end else if (accept) begin
      req_q   <= '{x: x_in, y: y_in, colour: colour_in};
      width_q <= eff_width;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= plot_d;
      done <= done_d;
      busy <= (next_state != IDLE);
      if (state == DRAW) begin
        vga_x      <= x_sum[X_W-1:0];
        vga_y      <= y_sum[Y_W-1:0];
        vga_colour <= req_q.colour;
      end
    end
  end

endmodule

// File: tb/tb_block_drawer.sv
// Self-checking bench for block_drawer against a per-pixel raster model of the block.
module tb_block_drawer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic [2:0] width_in = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  block_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .width_in   (width_in),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [15:0] k;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   exp_n;
  int   done_k;
  int   busy_n;
  int   done_n;
  int   checks = 0;
  int   errors = 0;

  // Every pixel of the block in raster order, tagged with the cycle after start it should appear.
  function automatic void model_draw(input int x, input int y, input int c, input int w);
    int weff;
    weff = (w > 4) ? 4 : w;
    exp_n = 16 * weff;
    exp_q.delete();
    for (int ry = 0; ry < 4; ry++)
      for (int cx = 0; cx < 4 * weff; cx++)
        if (x + cx < 160 && y + ry < 120)
          exp_q.push_back(pix_t'{16'(1 + ry * 4 * weff + cx), 8'(x + cx), 7'(y + ry), 3'(c)});
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Issues one start, scrambles the inputs afterwards, records every plot until done (bounded).
  task automatic capture_draw(input int x, input int y, input int c, input int w, input int poke_k);
    got_q.delete();
    done_k = -1;
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c); width_in = 3'(w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_n++;
    x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom); width_in = 3'($urandom);
    for (int k = 1; k <= 300 && done_k < 0; k++) begin
      @(negedge clk);
      if (plot) got_q.push_back(pix_t'{16'(k), vga_x, vga_y, vga_colour});
      if (busy) busy_n++;
      if (done) begin done_k = k; done_n++; end
      start = (k == poke_k);
      if (k == poke_k) colour_in = 3'b111;
    end
    @(negedge clk);
    start = 1'b0;
    if (done) done_n++;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({plot, done, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {plot, done, busy});
    end
    checks++;
    if ({vga_x, vga_y, vga_colour} !== 18'd0) begin
      errors++; $display("FAIL reset_pix got %h want 0", {vga_x, vga_y, vga_colour});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_bottom_edge();
    model_draw(0, 116, 2, 3);
    capture_draw(0, 116, 2, 3, -1);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bottom_count got %0d want %0d", got_q.size(), exp_q.size()); end
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL bottom_pixel idx %0d got %h want %h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
    checks++; if (done_k !== 49) begin errors++; $display("FAIL bottom_done_cycle got %0d want 49", done_k); end
    checks++; if (busy_n !== 49) begin errors++; $display("FAIL bottom_busy got %0d want 49", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL bottom_done_len got %0d want 1", done_n); end
  endtask

  task automatic test_right_edge();
    model_draw(152, 0, 4, 4);
    capture_draw(152, 0, 4, 4, -1);
    checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL right_count got %0d want 32", got_q.size()); end
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL right_pixel idx %0d got %h want %h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
    checks++; if (done_k !== 65) begin errors++; $display("FAIL right_done_cycle got %0d want 65", done_k); end
    checks++; if (busy_n !== 65) begin errors++; $display("FAIL right_busy got %0d want 65", busy_n); end
  endtask

  task automatic test_zero_width();
    capture_draw(30, 30, 5, 0, -1);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL zero_plots got %0d want 0", got_q.size()); end
    checks++; if (done_k !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", done_k); end
    checks++; if (busy_n !== 1) begin errors++; $display("FAIL zero_busy got %0d want 1", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL zero_done_len got %0d want 1", done_n); end
  endtask

  task automatic test_clamp_ignore();
    model_draw(10, 20, 3, 7);
    capture_draw(10, 20, 3, 7, 20);
    checks++; if (got_q.size() !== 64) begin errors++; $display("FAIL clamp_count got %0d want 64", got_q.size()); end
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL clamp_pixel idx %0d got %h want %h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
    checks++; if (done_k !== 65) begin errors++; $display("FAIL clamp_done_cycle got %0d want 65", done_k); end
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    @(negedge clk);
    x_in = 8'd20; y_in = 7'd30; colour_in = 3'd5; width_in = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({plot, done, busy} !== 3'b000) begin errors++; $display("FAIL abort_ctrl got %b want 000", {plot, done, busy}); end
    checks++; if ({vga_x, vga_y, vga_colour} !== 18'd0) begin errors++; $display("FAIL abort_pix got %h want 0", {vga_x, vga_y, vga_colour}); end
    repeat (2) begin @(negedge clk); seen += int'(done | busy | plot); end
    reset = 1'b0;
    repeat (5) begin @(negedge clk); seen += int'(done | busy | plot); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
    model_draw(4, 8, 6, 1);
    capture_draw(4, 8, 6, 1, -1);
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL abort_count got %0d want 16", got_q.size()); end
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL abort_pixel idx %0d got %h want %h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
    checks++; if (done_k !== 17) begin errors++; $display("FAIL abort_done_cycle got %0d want 17", done_k); end
  endtask

  task automatic test_erase();
    model_draw(40, 100, 0, 2);
    capture_draw(40, 100, 0, 2, -1);
    checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL erase_count got %0d want 32", got_q.size()); end
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL erase_pixel idx %0d got %h want %h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
  endtask

  task automatic test_back_to_back();
    int seen;
    // Start pulsed only in the DONE cycle must be dropped, not deferred.
    model_draw(60, 50, 1, 1);
    capture_draw(60, 50, 1, 1, 16);
    checks++; if (first_diff() !== -1 || got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_first got %0d pixels want %0d", got_q.size(), exp_q.size()); end
    seen = int'(busy);
    repeat (3) begin @(negedge clk); seen += int'(busy); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL b2b_done_start got %0d busy cycles want 0", seen); end
    model_draw(100, 70, 7, 2);
    capture_draw(100, 70, 7, 2, -1);
    checks++; if (first_diff() !== -1 || got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_second got %0d pixels want %0d", got_q.size(), exp_q.size()); end
    checks++; if (done_k !== 33) begin errors++; $display("FAIL b2b_done_cycle got %0d want 33", done_k); end
  endtask

  task automatic test_random();
    int x, y, c, w;
    for (int n = 0; n < 10; n++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 127));
      c = int'($urandom_range(0, 7));
      w = int'($urandom_range(0, 7));
      model_draw(x, y, c, w);
      capture_draw(x, y, c, w, int'($urandom_range(1, 40)));
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count x=%0d y=%0d w=%0d got %0d want %0d", x, y, w, got_q.size(), exp_q.size()); end
      checks++; if (first_diff() !== -1) begin errors++; $display("FAIL rand_pixel idx %0d got %h want %h", first_diff(), got_q[first_diff()], exp_q[first_diff()]); end
      checks++; if (done_k !== exp_n + 1) begin errors++; $display("FAIL rand_done_cycle w=%0d got %0d want %0d", w, done_k, exp_n + 1); end
      checks++; if (busy_n !== exp_n + 1) begin errors++; $display("FAIL rand_busy w=%0d got %0d want %0d", w, busy_n, exp_n + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_bottom_edge();
    test_right_edge();
    test_zero_width();
    test_clamp_ignore();
    test_reset_abort();
    test_erase();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
